// File: rtl/keypad_scan_ctrl_pkg.sv
// Shared types, key map and small helpers for the 4x4 keypad scanner.
package keypad_pkg;

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    HELD     = 2'd2,
    RELEASE  = 2'd3
  } scan_state_t;

  // Hex code printed on each key, indexed [row][col].
  localparam logic [3:0] KEY_MAP [0:3][0:3] = '{
    '{4'h1, 4'h2, 4'h3, 4'hA},
    '{4'h4, 4'h5, 4'h6, 4'hB},
    '{4'h7, 4'h8, 4'h9, 4'hC},
    '{4'hE, 4'h0, 4'hF, 4'hD}
  };

  // All rows idle (pulled up, nothing pressed in the driven column).
  localparam logic [3:0] ROWS_IDLE = 4'b1111;

  // Code for the key at a given row/column intersection.
  function automatic logic [3:0] key_lookup(input logic [1:0] row, input logic [1:0] col);
    return KEY_MAP[row][col];
  endfunction

  // Lowest-numbered row that is pulled low; only meaningful when some row is low.
  function automatic logic [1:0] lowest_low_row(input logic [3:0] rows);
    logic [1:0] idx;
    idx = 2'd3;
    if (!rows[0])      idx = 2'd0;
    else if (!rows[1]) idx = 2'd1;
    else if (!rows[2]) idx = 2'd2;
    return idx;
  endfunction

  // Active-low one-hot column drive for a column index.
  function automatic logic [3:0] col_drive(input logic [1:0] col);
    return ~(4'b0001 << col);
  endfunction

endpackage

// File: rtl/keypad_scan_ctrl_scan_tick.sv
// Free-running enable-pulse divider: one-cycle tick every DIV clocks.
module scan_tick #(
  parameter logic [23:0] DIV = 24'd48000
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  logic [23:0] cnt;

  assign tick = (cnt == DIV - 24'd1);

  // Count 0..DIV-1 and wrap on the tick cycle; never restarted by the scanner.
  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt <= 24'd0;
    end else if (tick) begin
      cnt <= 24'd0;
    end else begin
      cnt <= cnt + 24'd1;
    end
  end

endmodule

// File: rtl/keypad_scan_ctrl.sv
// 4x4 matrix keypad scanner with press/release debounce and one-pulse-per-press reporting.
module keypad_scan_ctrl
  import keypad_pkg::*;
#(
  parameter logic [23:0] SCAN_DIV       = 24'd48000,
  parameter logic [7:0]  DEBOUNCE_TICKS = 8'd20
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] rows,
  output logic [3:0] cols,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held
);

  logic [3:0]  rows_m;
  logic [3:0]  rows_s;
  logic        tick;

  scan_state_t state;
  scan_state_t state_nxt;
  logic [1:0]  col_idx;
  logic [1:0]  col_nxt;
  logic [1:0]  row_idx;
  logic [1:0]  row_nxt;
  logic [7:0]  dcnt;
  logic [7:0]  dcnt_nxt;
  logic        held_nxt;
  logic        accept;
  logic        row_low;
  logic        dcnt_done;

  // Two-flop synchronizer for the asynchronous row lines; idles as "nothing pressed".
  always_ff @(posedge clk) begin
    if (!reset) begin
      rows_m <= ROWS_IDLE;
      rows_s <= ROWS_IDLE;
    end else begin
      rows_m <= rows;
      rows_s <= rows_m;
    end
  end

  scan_tick #(
    .DIV (SCAN_DIV)
  ) u_scan_tick (
    .clk   (clk),
    .reset (reset),
    .tick  (tick)
  );

  // The column index doubles as the latched column once a press is seen, since it is frozen.
  assign cols      = col_drive(col_idx);
  assign row_low   = ~rows_s[row_idx];
  assign dcnt_done = (dcnt == DEBOUNCE_TICKS - 8'd1);

  // State and output registers; key_valid is a registered echo of the accepting tick.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= SCAN;
      col_idx   <= 2'd0;
      row_idx   <= 2'd0;
      dcnt      <= 8'd0;
      key_code  <= 4'h0;
      key_valid <= 1'b0;
      key_held  <= 1'b0;
    end else begin
      state     <= state_nxt;
      col_idx   <= col_nxt;
      row_idx   <= row_nxt;
      dcnt      <= dcnt_nxt;
      key_held  <= held_nxt;
      key_valid <= accept;
      if (accept) begin
        key_code <= key_lookup(row_idx, col_idx);
      end
    end
  end

  // Next-state logic, evaluated only on tick cycles; otherwise everything holds.
  always_comb begin
    state_nxt = state;
    col_nxt   = col_idx;
    row_nxt   = row_idx;
    dcnt_nxt  = dcnt;
    held_nxt  = key_held;
    accept    = 1'b0;

    if (tick) begin
      case (state)
        SCAN: begin
          if (rows_s != ROWS_IDLE) begin
            row_nxt   = lowest_low_row(rows_s);
            dcnt_nxt  = 8'd0;
            state_nxt = DEBOUNCE;
          end else begin
            col_nxt = col_idx + 2'd1;
          end
        end

        DEBOUNCE: begin
          if (row_low) begin
            if (dcnt_done) begin
              accept    = 1'b1;
              held_nxt  = 1'b1;
              state_nxt = HELD;
            end else begin
              dcnt_nxt = dcnt + 8'd1;
            end
          end else begin
            state_nxt = SCAN;
          end
        end

        HELD: begin
          if (!row_low) begin
            dcnt_nxt  = 8'd0;
            state_nxt = RELEASE;
          end
        end

        RELEASE: begin
          if (!row_low) begin
            if (dcnt_done) begin
              held_nxt  = 1'b0;
              col_nxt   = col_idx + 2'd1;
              state_nxt = SCAN;
            end else begin
              dcnt_nxt = dcnt + 8'd1;
            end
          end else begin
            dcnt_nxt = 8'd0;
          end
        end

        default: begin
          state_nxt = SCAN;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Directed bench for keypad_scan_ctrl with a small switch-matrix model of the keypad.
module tb_keypad_scan_ctrl;

  logic        clk;
  logic        reset;
  logic [3:0]  rows;
  logic [3:0]  cols;
  logic [3:0]  key_code;
  logic        key_valid;
  logic        key_held;

  logic [15:0] pressed;
  int          tests_run;
  int          tests_failed;
  int          pulse_count;

  keypad_scan_ctrl #(
    .SCAN_DIV       (24'd4),
    .DEBOUNCE_TICKS (8'd3)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .rows      (rows),
    .cols      (cols),
    .key_code  (key_code),
    .key_valid (key_valid),
    .key_held  (key_held)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Keypad model: a row reads low when a pressed key connects it to a driven-low column.
  always_comb begin
    rows = 4'b1111;
    for (int r = 0; r < 4; r++) begin
      rows[r] = ~|(pressed[r*4 +: 4] & ~cols);
    end
  end

  // Count every cycle key_valid is high, sampled away from the active edge.
  always @(negedge clk) begin
    if (key_valid === 1'b1) pulse_count++;
  end

  function automatic logic [15:0] key_bit(input int r, input int c);
    logic [15:0] one;
    one = 16'd1;
    return one << (r * 4 + c);
  endfunction

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [15:0] keys);
    pressed = keys;
  endtask

  task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
    tests_run++;
    assert (observed === expected)
    else begin
      tests_failed++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    pulse_count  = 0;
    reset        = 1'b0;
    pressed      = 16'd0;

    // Reset state
    cycles(3);
    checkOutput("rst_cols",  {4'h0, cols},     8'h0E);
    checkOutput("rst_code",  {4'h0, key_code}, 8'h00);
    checkOutput("rst_valid", {7'd0, key_valid}, 8'h00);
    checkOutput("rst_held",  {7'd0, key_held},  8'h00);
    reset = 1'b1;

    // Idle scan: one column step every 4 cycles
    cycles(3);  checkOutput("scan_c0",  {4'h0, cols}, 8'h0E);
    cycles(1);  checkOutput("scan_c1",  {4'h0, cols}, 8'h0D);
    cycles(4);  checkOutput("scan_c2",  {4'h0, cols}, 8'h0B);
    cycles(4);  checkOutput("scan_c3",  {4'h0, cols}, 8'h07);
    cycles(4);  checkOutput("scan_wrap", {4'h0, cols}, 8'h0E);
    cycles(4);  checkOutput("scan_c1b", {4'h0, cols}, 8'h0D);

    // Press row1/col1 (key 5)
    applyStimulus(key_bit(1, 1));
    cycles(15);
    checkOutput("k5_pre_valid", {7'd0, key_valid}, 8'h00);
    checkOutput("k5_pre_held",  {7'd0, key_held},  8'h00);
    checkOutput("k5_frozen",    {4'h0, cols},      8'h0D);
    checkOutput("k5_pre_code",  {4'h0, key_code},  8'h00);
    cycles(1);
    checkOutput("k5_valid", {7'd0, key_valid}, 8'h01);
    checkOutput("k5_code",  {4'h0, key_code},  8'h05);
    checkOutput("k5_held",  {7'd0, key_held},  8'h01);
    cycles(1);
    checkOutput("k5_valid_drop", {7'd0, key_valid}, 8'h00);
    checkOutput("k5_held_on",    {7'd0, key_held},  8'h01);
    cycles(8);
    checkOutput("k5_held_cols", {4'h0, cols}, 8'h0D);
    checkOutput("k5_pulses",    8'(pulse_count), 8'd1);

    // Second key in another row while held, then release both
    applyStimulus(key_bit(1, 1) | key_bit(2, 1));
    cycles(4);
    checkOutput("two_held",  {7'd0, key_held}, 8'h01);
    checkOutput("two_cols",  {4'h0, cols},     8'h0D);
    applyStimulus(16'd0);
    cycles(14);
    checkOutput("rel_held_still", {7'd0, key_held}, 8'h01);
    cycles(1);
    checkOutput("rel_held_drop", {7'd0, key_held}, 8'h00);
    checkOutput("rel_next_col",  {4'h0, cols},     8'h0B);
    checkOutput("rel_pulses",    8'(pulse_count),  8'd1);

    // Bouncing press rejected during debounce
    cycles(12);
    checkOutput("bnc_cols_start", {4'h0, cols}, 8'h0D);
    applyStimulus(key_bit(1, 1));
    cycles(3);  applyStimulus(16'd0);
    cycles(3);  applyStimulus(key_bit(1, 1));
    cycles(3);  applyStimulus(16'd0);
    cycles(2);
    checkOutput("bnc_cols_hold", {4'h0, cols}, 8'h0D);
    cycles(1);
    checkOutput("bnc_resume", {4'h0, cols},     8'h0B);
    checkOutput("bnc_pulses", 8'(pulse_count),  8'd1);
    checkOutput("bnc_code",   {4'h0, key_code}, 8'h05);
    checkOutput("bnc_held",   {7'd0, key_held}, 8'h00);

    // Keys 1 and 4 together in column 0: lowest row wins
    cycles(8);
    checkOutput("k1_cols", {4'h0, cols}, 8'h0E);
    applyStimulus(key_bit(0, 0) | key_bit(1, 0));
    cycles(15);
    checkOutput("k1_pre_code",  {4'h0, key_code},  8'h05);
    checkOutput("k1_pre_valid", {7'd0, key_valid}, 8'h00);
    cycles(1);
    checkOutput("k1_valid", {7'd0, key_valid}, 8'h01);
    checkOutput("k1_code",  {4'h0, key_code},  8'h01);
    applyStimulus(16'd0);
    cycles(16);
    checkOutput("k1_rel_held", {7'd0, key_held}, 8'h00);
    checkOutput("k1_rel_cols", {4'h0, cols},     8'h0D);

    // Row3/col3 (key D)
    cycles(8);
    checkOutput("kd_cols", {4'h0, cols}, 8'h07);
    applyStimulus(key_bit(3, 3));
    cycles(16);
    checkOutput("kd_valid", {7'd0, key_valid}, 8'h01);
    checkOutput("kd_code",  {4'h0, key_code},  8'h0D);
    cycles(1);
    checkOutput("kd_held", {7'd0, key_held}, 8'h01);

    // Reset while held, key stays pressed
    reset = 1'b0;
    cycles(1);
    checkOutput("hrst_held",  {7'd0, key_held},  8'h00);
    checkOutput("hrst_valid", {7'd0, key_valid}, 8'h00);
    checkOutput("hrst_code",  {4'h0, key_code},  8'h00);
    checkOutput("hrst_cols",  {4'h0, cols},      8'h0E);
    reset = 1'b1;
    cycles(27);
    checkOutput("redet_pre_valid", {7'd0, key_valid}, 8'h00);
    checkOutput("redet_pre_held",  {7'd0, key_held},  8'h00);
    cycles(1);
    checkOutput("redet_valid", {7'd0, key_valid}, 8'h01);
    checkOutput("redet_code",  {4'h0, key_code},  8'h0D);
    checkOutput("redet_held",  {7'd0, key_held},  8'h01);
    cycles(12);
    checkOutput("redet_pulses", 8'(pulse_count), 8'd4);
    checkOutput("redet_cols",   {4'h0, cols},    8'h07);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
